// File: rtl/tmr_err_logger.sv
// tmr_err_logger: counts and captures voter mismatch events from a triplicated 2-bit stage
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   data_in    - data output of the upstream TMR stage
//   err_in     - error-sink output of the upstream TMR stage, synchronous to clk
//   clear_req  - supervisor clear request, four-phase level handshake
//   err_count  - saturating number of error events since the last clear
//   err_sticky - high while at least one error is logged
//   persistent - err_in was high for PERSIST_CYCLES consecutive samples
//   fault_data - data_in captured at the first event after a clear
//   clear_ack  - clear handshake acknowledge
module tmr_err_logger #(
    parameter int COUNT_W        = 8,
    parameter int PERSIST_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         data_in,
    input  logic               err_in,
    input  logic               clear_req,
    output logic [COUNT_W-1:0] err_count,
    output logic               err_sticky,
    output logic               persistent,
    output logic [1:0]         fault_data,
    output logic               clear_ack
);
    typedef enum logic [1:0] {MONITOR, FAULT, ACK} state_t;
    localparam logic [7:0] PC = 8'(PERSIST_CYCLES);
    state_t             state_q;
    logic               err_q;
    logic [7:0]         run_q;
    logic [COUNT_W-1:0] cnt_q;
    logic               sticky_q;
    logic               pers_q;
    logic [1:0]         fdata_q;
    logic               ack_q;
    logic               evt;
    logic [7:0]         run_d;
    always_comb begin
        evt   = err_in & ~err_q;
        run_d = (run_q == PC) ? run_q : run_q + 8'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MONITOR;
            err_q    <= 1'b0;
            run_q    <= 8'd0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            pers_q   <= 1'b0;
            fdata_q  <= 2'b00;
            ack_q    <= 1'b0;
        end else begin
            // err_q tracks err_in in every state so a held level is never recounted
            err_q <= err_in;
            case (state_q)
                MONITOR, FAULT: begin
                    if (clear_req) begin
                        // clear wins over any same-cycle event or run update
                        cnt_q    <= '0;
                        sticky_q <= 1'b0;
                        pers_q   <= 1'b0;
                        fdata_q  <= 2'b00;
                        run_q    <= 8'd0;
                        ack_q    <= 1'b1;
                        state_q  <= ACK;
                    end else begin
                        run_q <= err_in ? run_d : 8'd0;
                        if (err_in && run_d == PC) pers_q <= 1'b1;
                        if (evt) begin
                            if (state_q == MONITOR) begin
                                cnt_q    <= {{(COUNT_W-1){1'b0}}, 1'b1};
                                fdata_q  <= data_in;
                                sticky_q <= 1'b1;
                                state_q  <= FAULT;
                            end else if (cnt_q != '1) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                end
                ACK: begin
                    run_q <= 8'd0;
                    if (!clear_req) begin
                        ack_q   <= 1'b0;
                        state_q <= MONITOR;
                    end
                end
                default: state_q <= MONITOR;
            endcase
        end
    end
    assign err_count  = cnt_q;
    assign err_sticky = sticky_q;
    assign persistent = pers_q;
    assign fault_data = fdata_q;
    assign clear_ack  = ack_q;
endmodule

// File: tb/tb_tmr_err_logger.sv
// tb_tmr_err_logger: directed-vector bench for tmr_err_logger (default and 2-bit/1-cycle variants)
module tb_tmr_err_logger;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       err_in = 1'b0;
    logic       clear_req = 1'b0;
    logic [7:0] err_count;
    logic       err_sticky, persistent, clear_ack;
    logic [1:0] fault_data;
    logic [1:0] s_count;
    logic       s_sticky, s_pers, s_ack;
    logic [1:0] s_fdata;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    tmr_err_logger u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .err_in(err_in), .clear_req(clear_req),
        .err_count(err_count), .err_sticky(err_sticky), .persistent(persistent),
        .fault_data(fault_data), .clear_ack(clear_ack)
    );

    tmr_err_logger #(.COUNT_W(2), .PERSIST_CYCLES(1)) u_sat (
        .clk(clk), .rst(rst), .data_in(data_in), .err_in(err_in), .clear_req(clear_req),
        .err_count(s_count), .err_sticky(s_sticky), .persistent(s_pers),
        .fault_data(s_fdata), .clear_ack(s_ack)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] d);
        data_in = d;
        err_in  = 1'b1;
        tick();
        err_in  = 1'b0;
        tick();
    endtask

    task automatic chk_clear(input string tag);
        chk({tag, "_cnt"}, err_count, 0);
        chk({tag, "_sticky"}, err_sticky, 0);
        chk({tag, "_pers"}, persistent, 0);
        chk({tag, "_fdata"}, fault_data, 0);
    endtask

    initial begin
        // asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk_clear("rst");
        chk("rst_ack", clear_ack, 0);
        chk("rst_s_cnt", s_count, 0);
        tick();
        tick();
        #2 rst = 1'b0;

        // 1: single pulse captures data and counts once
        data_in = 2'b10;
        err_in  = 1'b1;
        tick();
        chk("t1_cnt", err_count, 1);
        chk("t1_sticky", err_sticky, 1);
        chk("t1_fdata", fault_data, 2);
        chk("t1_pers", persistent, 0);
        chk("t1_s_pers", s_pers, 1);
        chk("t1_s_cnt", s_count, 1);
        err_in = 1'b0;
        tick();

        // 2: further pulses count but never overwrite fault_data
        pulse(2'b01);
        pulse(2'b11);
        chk("t2_cnt", err_count, 3);
        chk("t2_fdata", fault_data, 2);
        chk("t2_pers", persistent, 0);
        chk("t2_s_cnt", s_count, 3);

        // 4: 2-bit counter saturates at 3 and stays there
        pulse(2'b00);
        chk("t4_s_cnt4", s_count, 3);
        pulse(2'b00);
        chk("t4_s_cnt5", s_count, 3);
        chk("t4_cnt5", err_count, 5);

        // clear handshake
        clear_req = 1'b1;
        tick();
        chk("clr_ack", clear_ack, 1);
        chk_clear("clr");
        chk("clr_s_pers", s_pers, 0);
        tick();
        chk("clr_ack_hold", clear_ack, 1);
        clear_req = 1'b0;
        tick();
        chk("clr_ack_drop", clear_ack, 0);

        // 3: level held 6 cycles counts once, persistent on 4th sampled-high edge
        err_in = 1'b1;
        tick();
        chk("t3_cnt1", err_count, 1);
        tick();
        tick();
        chk("t3_pers3", persistent, 0);
        tick();
        chk("t3_pers4", persistent, 1);
        tick();
        tick();
        chk("t3_cnt6", err_count, 1);
        chk("t3_pers6", persistent, 1);
        err_in = 1'b0;
        tick();

        // 5: clear and event in the same cycle, event dropped
        clear_req = 1'b1;
        err_in    = 1'b1;
        tick();
        chk("t5_ack", clear_ack, 1);
        chk_clear("t5");
        chk("t5_s_pers", s_pers, 0);
        chk("t5_s_cnt", s_count, 0);
        err_in = 1'b0;
        tick();
        pulse(2'b01);
        chk("t5_ack_hold", clear_ack, 1);
        chk("t5_cnt_ack", err_count, 0);
        clear_req = 1'b0;
        tick();
        chk("t5_ack_drop", clear_ack, 0);
        pulse(2'b01);
        chk("t5_cnt_after", err_count, 1);
        chk("t5_fdata_after", fault_data, 1);
        chk("t5_sticky_after", err_sticky, 1);

        // 6: reset mid-ACK
        clear_req = 1'b1;
        tick();
        chk("t6_ack_pre", clear_ack, 1);
        rst = 1'b1;
        #1;
        chk("t6_ack_rst", clear_ack, 0);
        clear_req = 1'b0;
        #2 rst = 1'b0;

        // 6: reset mid-run with err_in held high
        err_in = 1'b1;
        data_in = 2'b11;
        tick();
        tick();
        chk("t6_cnt_run", err_count, 1);
        rst = 1'b1;
        #1;
        chk_clear("t6_rst");
        #2 rst = 1'b0;
        tick();
        chk("t6_cnt_first", err_count, 1);
        chk("t6_fdata_first", fault_data, 3);
        tick();
        tick();
        chk("t6_cnt_held", err_count, 1);
        chk("t6_pers_held", persistent, 0);
        err_in = 1'b0;
        tick();
        err_in = 1'b1;
        tick();
        chk("t6_cnt_rise", err_count, 2);
        err_in = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
